// File: rtl/seg_scan_controller.sv
// -----------------------------------------------------------------------------
// seg_scan_controller
//   Time-multiplexed driver for an N-digit common-anode 7-segment display that
//   shares one segment bus. Digits are scanned round-robin (0,1,...,N-1). Only
//   one anode is active at a time, and a dark gap separates successive digits.
//   New display data arrives through a load strobe into a pending register. It
//   is committed to the displayed (shadow) register only at a frame boundary,
//   so a frame never mixes old and new values.
//
// Parameters
//   NUM_DIGITS   digits scanned (2..8)
//   SHOW_CYCLES  clk cycles each digit is lit (>=2)
//   GAP_CYCLES   clk cycles all anodes are dark between digits (>=1)
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active-high
//   load        in   one-cycle strobe: capture value/blank_mask as pending
//   value       in   4*NUM_DIGITS hex nibbles, digit k = value[4k+3:4k]
//   blank_mask  in   NUM_DIGITS, 1 = digit k forced dark
//   upd_ack     out  one-cycle pulse: pending data committed to display
//   frame_done  out  one-cycle pulse: last digit's gap completed
//   an_n        out  NUM_DIGITS anode enables, active-low
//   seg_n       out  segments {a,b,c,d,e,f,g}, active-low
//
// Optional feature (compile-time macro)
//   LEADING_ZERO_BLANK_EN : at commit, digits whose nibble and all higher
//   nibbles are zero are blanked as well (digit 0 is never auto-blanked).
// -----------------------------------------------------------------------------
module seg_scan_controller #(
   parameter int NUM_DIGITS  = 4,
   parameter int SHOW_CYCLES = 50000,
   parameter int GAP_CYCLES  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic [NUM_DIGITS-1:0]     blank_mask,
   output logic                      upd_ack,
   output logic                      frame_done,
   output logic [NUM_DIGITS-1:0]     an_n,
   output logic [6:0]                seg_n
);

   localparam int CNT_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int IDX_W   = $clog2(NUM_DIGITS);

   typedef enum logic {
      ST_SHOW = 1'b0,
      ST_GAP  = 1'b1
   } state_t;

   // Active-low segment pattern {a,b,c,d,e,f,g} for one hex nibble.
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   // Digit k (k>=1) is a leading zero when it and every higher nibble are 0.
   function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] v);
      logic [NUM_DIGITS-1:0] m;
      logic                  zero_above;
      m          = '0;
      zero_above = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_above = zero_above & (v[4*k +: 4] == 4'h0);
         m[k]       = zero_above;
      end
      return m;
   endfunction

   state_t                   state, state_nxt;
   logic [CNT_W-1:0]         cnt, cnt_nxt;
   logic [IDX_W-1:0]         idx, idx_nxt;
   logic                     boundary;
   logic [NUM_DIGITS-1:0]    an_nxt;
   logic [6:0]               seg_nxt;

   logic [4*NUM_DIGITS-1:0]  shadow_val;
   logic [NUM_DIGITS-1:0]    shadow_mask;
   logic [4*NUM_DIGITS-1:0]  pend_val;
   logic [NUM_DIGITS-1:0]    pend_mask;
   logic                     pend_vld;
   logic [NUM_DIGITS-1:0]    commit_mask;

`ifdef LEADING_ZERO_BLANK_EN
   assign commit_mask = pend_mask | lz_mask(pend_val);
`else
   assign commit_mask = pend_mask;
`endif

   // Scan state register: one counter times both SHOW and GAP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_GAP;
         cnt   <= '0;
         idx   <= IDX_W'(NUM_DIGITS - 1);
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
      end
   end

   // Next-state and next-output logic. Outputs are computed from the current
   // state and registered, so pins follow the state one clock later.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      idx_nxt   = idx;
      boundary  = 1'b0;
      an_nxt    = '1;
      seg_nxt   = 7'h7F;
      case (state)
         ST_SHOW: begin
            if (!shadow_mask[idx]) begin
               an_nxt  = ~(NUM_DIGITS'(1) << idx);
               seg_nxt = seg_decode(shadow_val[{idx, 2'b00} +: 4]);
            end
            if (cnt == CNT_W'(SHOW_CYCLES - 1)) begin
               state_nxt = ST_GAP;
               cnt_nxt   = '0;
            end
         end
         ST_GAP: begin
            if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
               state_nxt = ST_SHOW;
               cnt_nxt   = '0;
               if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                  // Wrap to digit 0: this is the frame boundary.
                  idx_nxt  = '0;
                  boundary = 1'b1;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Registered outputs, pending/shadow data and handshake pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_n        <= '1;
         seg_n       <= 7'h7F;
         upd_ack     <= 1'b0;
         frame_done  <= 1'b0;
         shadow_val  <= '0;
         shadow_mask <= '0;
         pend_val    <= '0;
         pend_mask   <= '0;
         pend_vld    <= 1'b0;
      end else begin
         an_n       <= an_nxt;
         seg_n      <= seg_nxt;
         frame_done <= boundary;
         upd_ack    <= boundary & pend_vld;
         if (boundary && pend_vld) begin
            shadow_val  <= pend_val;
            shadow_mask <= commit_mask;
         end
         // A load in the boundary cycle wins over the clear: the old pending
         // data is committed above and the new one waits for the next frame.
         if (load) begin
            pend_val  <= value;
            pend_mask <= blank_mask;
            pend_vld  <= 1'b1;
         end else if (boundary) begin
            pend_vld <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_controller
//   Directed bench for seg_scan_controller with NUM_DIGITS=4, SHOW_CYCLES=8,
//   GAP_CYCLES=2 (frame period 40 clocks). A table of frames drives loads and
//   lists the expected digit patterns for the following frame; hand-written
//   sequences cover reset, boundary-cycle loads and mid-scan reset.
// -----------------------------------------------------------------------------
module tb_seg_scan_controller;

   localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                          S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                          S6 = 7'b0100000, S7 = 7'b0001111, S8 = 7'b0000000,
                          S9 = 7'b0000100, SA = 7'b0001000, SB = 7'b1100000,
                          SC = 7'b0110001, SD = 7'b1000010, SE = 7'b0110000,
                          SF = 7'b0111000, DARK = 7'h7F;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = 16'h0;
   logic [3:0]  blank_mask = 4'h0;
   logic        upd_ack, frame_done;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;

   int n_cmp = 0;
   int n_err = 0;

   seg_scan_controller #(.NUM_DIGITS(4), .SHOW_CYCLES(8), .GAP_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .load(load), .value(value), .blank_mask(blank_mask),
      .upd_ack(upd_ack), .frame_done(frame_done), .an_n(an_n), .seg_n(seg_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            ld1;
      logic [15:0]     v1;
      logic [3:0]      m;
      logic            ld2;
      logic [15:0]     v2;
      logic            ack;
      logic [3:0][6:0] es;
      logic [3:0]      eb;
   } row_t;

   row_t tbl[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int t, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0d: got %h, expected %h", nm, t, act, exp);
      end
   endtask

   // Starts just after a boundary edge; checks 40 clocks up to the next one.
   task automatic check_frame(input string nm, input logic [3:0][6:0] es, input logic [3:0] eb,
                              input logic ld1, input logic [15:0] v1, input logic [3:0] m,
                              input logic ld2, input logic [15:0] v2,
                              input logic ldb, input logic [15:0] vb, input logic exp_ack);
      logic [3:0] one;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      one = 4'b0001;
      for (int t = 1; t <= 40; t++) begin
         int k, c;
         load = 1'b0;
         if (ld1 && t == 13) begin load = 1'b1; value = v1; blank_mask = m; end
         if (ld2 && t == 25) begin load = 1'b1; value = v2; blank_mask = m; end
         if (ldb && t == 40) begin load = 1'b1; value = vb; blank_mask = m; end
         tick();
         k = (t - 1) / 10;
         c = (t - 1) % 10;
         if (c < 8 && !eb[k]) begin
            exp_an  = ~(one << k);
            exp_seg = es[k];
         end else begin
            exp_an  = 4'hF;
            exp_seg = DARK;
         end
         chk({nm, " an_n"}, t, 16'(an_n), 16'(exp_an));
         chk({nm, " seg_n"}, t, 16'(seg_n), 16'(exp_seg));
         chk({nm, " frame_done"}, t, 16'(frame_done), 16'(t == 40));
         chk({nm, " upd_ack"}, t, 16'(upd_ack), 16'((t == 40) && exp_ack));
      end
      load = 1'b0;
   endtask

   // Holds reset, checks the dark state, releases it and checks the first
   // GAP_CYCLES of dark up to the first boundary (no commit expected).
   task automatic reset_seq(input string nm);
      rst = 1'b1;
      load = 1'b0;
      tick();
      tick();
      chk({nm, " rst an_n"}, 0, 16'(an_n), 16'hF);
      chk({nm, " rst seg_n"}, 0, 16'(seg_n), 16'(DARK));
      chk({nm, " rst upd_ack"}, 0, 16'(upd_ack), 16'h0);
      chk({nm, " rst frame_done"}, 0, 16'(frame_done), 16'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk({nm, " gap1 an_n"}, 1, 16'(an_n), 16'hF);
      chk({nm, " gap1 frame_done"}, 1, 16'(frame_done), 16'h0);
      tick();
      chk({nm, " gap2 an_n"}, 2, 16'(an_n), 16'hF);
      chk({nm, " gap2 seg_n"}, 2, 16'(seg_n), 16'(DARK));
      chk({nm, " first frame_done"}, 2, 16'(frame_done), 16'h1);
      chk({nm, " first upd_ack"}, 2, 16'(upd_ack), 16'h0);
   endtask

   initial begin
      logic [3:0][6:0] cur_es;
      logic [3:0]      cur_eb;

      tbl[0] = '{1'b1, 16'h12AF, 4'h0, 1'b0, 16'h0,    1'b1, {S1, S2, SA, SF}, 4'h0};
      tbl[1] = '{1'b1, 16'h1111, 4'h0, 1'b1, 16'h2222, 1'b1, {S2, S2, S2, S2}, 4'h0};
      tbl[2] = '{1'b1, 16'h3456, 4'h4, 1'b0, 16'h0,    1'b1, {S3, S4, S5, S6}, 4'h4};
      tbl[3] = '{1'b1, 16'h789B, 4'h0, 1'b0, 16'h0,    1'b1, {S7, S8, S9, SB}, 4'h0};
      tbl[4] = '{1'b0, 16'h0,    4'h0, 1'b0, 16'h0,    1'b0, {S7, S8, S9, SB}, 4'h0};
      tbl[5] = '{1'b1, 16'hCDE0, 4'h8, 1'b0, 16'h0,    1'b1, {SC, SD, SE, S0}, 4'h8};
`ifdef LEADING_ZERO_BLANK_EN
      tbl[6] = '{1'b1, 16'h0040, 4'h0, 1'b0, 16'h0,    1'b1, {S0, S0, S4, S0}, 4'hC};
      tbl[7] = '{1'b1, 16'h0000, 4'h0, 1'b0, 16'h0,    1'b1, {S0, S0, S0, S0}, 4'hE};
`else
      tbl[6] = '{1'b1, 16'h0040, 4'h0, 1'b0, 16'h0,    1'b1, {S0, S0, S4, S0}, 4'h0};
      tbl[7] = '{1'b1, 16'h0000, 4'h0, 1'b0, 16'h0,    1'b1, {S0, S0, S0, S0}, 4'h0};
`endif

      reset_seq("init");

      // Table frames: loads during frame i, frame i+1 shows row i.
      cur_es = {S0, S0, S0, S0};
      cur_eb = 4'h0;
      for (int i = 0; i < 8; i++) begin
         check_frame($sformatf("row%0d", i), cur_es, cur_eb,
                     tbl[i].ld1, tbl[i].v1, tbl[i].m, tbl[i].ld2, tbl[i].v2,
                     1'b0, 16'h0, tbl[i].ack);
         cur_es = tbl[i].es;
         cur_eb = tbl[i].eb;
      end
      check_frame("row_last", cur_es, cur_eb, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);

      // Load in the boundary cycle with nothing pending: committed a frame later.
      check_frame("bnd_empty", cur_es, cur_eb, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 1'b1, 16'h5A5A, 1'b0);
      check_frame("bnd_wait", cur_es, cur_eb, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
      cur_es = {S5, SA, S5, SA};
      cur_eb = 4'h0;
      check_frame("bnd_show", cur_es, cur_eb, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);

      // Pending full plus boundary load: old pending commits, new one next frame.
      check_frame("bnd_full", cur_es, cur_eb, 1'b1, 16'h1234, 4'h0, 1'b0, 16'h0, 1'b1, 16'h4321, 1'b1);
      cur_es = {S1, S2, S3, S4};
      check_frame("bnd_old", cur_es, cur_eb, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
      cur_es = {S4, S3, S2, S1};

      // Mid-scan reset during digit 1: dark immediately, data lost afterwards.
      for (int t = 1; t <= 13; t++) tick();
      chk("pre_rst an_n", 13, 16'(an_n), 16'hD);
      chk("pre_rst seg_n", 13, 16'(seg_n), 16'(S2));
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst an_n", 0, 16'(an_n), 16'hF);
      chk("async_rst seg_n", 0, 16'(seg_n), 16'(DARK));
      reset_seq("mid");
      check_frame("after_rst", {S0, S0, S0, S0}, 4'h0, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
